taiga_event_counters: RTL and testbench
=======================================

Name: taiga_event_counters

Overview:
Parametrised performance-event counter bank for the Taiga core, fed by the registered trace-event signals (operand_stall, branch_misspredict, num_instructions_completing, ...). Provides NUM_EVENTS counters of configurable width and per-event increment width. Supports free-running and fixed-cycle-window measurement modes, atomic snapshot into shadow registers, and a registered single-port read interface for a CSR or debug bridge.

Parameters:
NUM_EVENTS, 27, number of event channels
INC_W, 3, increment width per channel; single-bit events are tied zero-extended
COUNTER_W, 32, counter and shadow register width, 8..64
SATURATE, 0, 1 = counters saturate at all-ones, 0 = wrap to zero
WINDOW_W, 24, width of the window-length register

Ports:
clk  in  1  core clock
rst  in  1  synchronous, active-low reset
events  in  NUM_EVENTS*INC_W  flattened per-channel increments; channel i is bits [i*INC_W +: INC_W]
count_en  in  1  global count enable, free-running mode only
clear  in  1  pulse; zero all live counters and overflow flags
snapshot  in  1  pulse; copy live counters to shadow
win_start  in  1  pulse; begin a measurement window
win_len  in  WINDOW_W  window length in cycles, sampled on win_start
win_busy  out  1  window in progress
win_done  out  1  one-cycle pulse at window end
rd_req  in  1  read request
rd_sel  in  $clog2(NUM_EVENTS)+1  shadow index; MSB set = overflow-flag word
rd_valid  out  1  read data valid, 1 cycle after rd_req
rd_data  out  COUNTER_W  shadow value or packed overflow flags, zero-extended or truncated to COUNTER_W
rd_err  out  1  with rd_valid, index out of range
overflow  out  NUM_EVENTS  sticky per-channel overflow flags

Behaviour:
- Reset (rst == 0 at clk edge): all counters, shadows, overflow flags, window counter = 0; FSM = IDLE; win_busy, win_done, rd_valid, rd_err = 0; rd_data = 0.
- Input stage: events registered once, so an increment presented at cycle N is visible in its counter at cycle N+2 and in the shadow after a snapshot at N+2 or later.
- Count update: cnt_i <= cnt_i + inc_i when counting is active.
  - Carry out with SATURATE = 0: counter wraps and overflow[i] is set.
  - Carry out with SATURATE = 1: counter holds all-ones and overflow[i] is set.
  - overflow[i] is sticky until clear or win_start.
- Counting active: in IDLE when count_en = 1; always in COUNTING; never in DONE.
- FSM:
  - IDLE -> COUNTING on win_start with win_len != 0: clears counters and flags, loads remaining = win_len.
  - win_start with win_len == 0 is ignored.
  - COUNTING: remaining decrements each cycle, so exactly win_len cycles are counted. At remaining == 1 the final increment is applied, shadows take the post-increment values, and the FSM enters DONE.
  - DONE: win_done = 1 for one cycle, then IDLE.
  - win_start while COUNTING restarts the window: counters cleared, remaining reloaded.
  - win_busy = 1 exactly in COUNTING.
- Priority within a cycle, highest first: rst, win_start, clear, increment. clear beats increment, so the counter reads 0 next cycle.
- snapshot together with clear: shadows capture the pre-clear values.
- snapshot during COUNTING: accepted; shadows overwritten with live values.
- Read path:
  - rd_valid asserts the cycle after rd_req and carries rd_sel's shadow.
  - Back-to-back reads every cycle are supported.
  - rd_sel >= NUM_EVENTS with MSB clear: rd_data = 0, rd_err = 1.
  - Reads never disturb counters.

Optional Feature:
TAIGA_EVENT_COUNTER_IRQ_EN
- Defined: adds output ctr_irq (1 bit) and input irq_mask (NUM_EVENTS).
  - ctr_irq is registered and equals OR(overflow & ~irq_mask) | win_done_latched.
  - win_done_latched sets on win_done and clears on clear or win_start.
  - ctr_irq resets to 0.
- Undefined: ports absent, no extra logic. All other behaviour identical.

Test Plan:
- Reset mid-window (win_len = 100, rst low at cycle 50) -> next cycle win_busy = 0, all rd_data = 0, overflow = 0.
- count_en = 1, channel 3 inc = 1 for 10 cycles, snapshot, read sel 3 -> rd_valid one cycle later, rd_data = 10, rd_err = 0.
- COUNTER_W = 8, SATURATE = 0, channel 0 inc = 5 for 52 cycles -> count 260 wraps to 4, overflow[0] = 1; with SATURATE = 1 -> 255, overflow[0] = 1.
- win_start, win_len = 16, channel 1 inc = 2 every cycle -> win_done pulses once; shadow[1] = 32; win_busy high exactly 16 cycles; further increments not counted.
- clear and snapshot in the same cycle with counter 7 -> shadow = 7, live counter = 0; rd_sel = NUM_EVENTS -> rd_data = 0, rd_err = 1.
- TAIGA_EVENT_COUNTER_IRQ_EN: overflow on channel 2 with irq_mask[2] = 1 -> ctr_irq stays 0; unmask -> ctr_irq = 1 next cycle; clear -> 0.

Source files
------------

// File: rtl/taiga_event_counters.sv
// Performance-event counter bank: live counters, shadow snapshot, measurement window FSM
// and a registered read port. Optional interrupt output enabled by TAIGA_EVENT_COUNTER_IRQ_EN.
module taiga_event_counters #(
    parameter int unsigned NUM_EVENTS = 27,
    parameter int unsigned INC_W      = 3,
    parameter int unsigned COUNTER_W  = 32,
    parameter int unsigned SATURATE   = 0,
    parameter int unsigned WINDOW_W   = 24
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NUM_EVENTS*INC_W-1:0]   events_i,
    input  logic                          count_en_i,
    input  logic                          clear_i,
    input  logic                          snapshot_i,
    input  logic                          win_start_i,
    input  logic [WINDOW_W-1:0]           win_len_i,
    output logic                          win_busy_o,
    output logic                          win_done_o,
    input  logic                          rd_req_i,
    input  logic [$clog2(NUM_EVENTS):0]   rd_sel_i,
    output logic                          rd_valid_o,
    output logic [COUNTER_W-1:0]          rd_data_o,
    output logic                          rd_err_o,
    output logic [NUM_EVENTS-1:0]         overflow_o
`ifdef TAIGA_EVENT_COUNTER_IRQ_EN
    ,
    output logic                          ctr_irq_o,
    input  logic [NUM_EVENTS-1:0]         irq_mask_i
`endif
);

    localparam int unsigned SEL_W    = $clog2(NUM_EVENTS) + 1;
    localparam int unsigned OVF_BITS = (NUM_EVENTS < COUNTER_W) ? NUM_EVENTS : COUNTER_W;

    typedef enum logic [1:0] {IDLE, COUNTING, DONE} state_e;

    state_e                      state_q, state_d;
    logic [NUM_EVENTS*INC_W-1:0] events_q;
    logic [COUNTER_W-1:0]        cnt_q    [NUM_EVENTS];
    logic [COUNTER_W-1:0]        cnt_d    [NUM_EVENTS];
    logic [COUNTER_W-1:0]        shadow_q [NUM_EVENTS];
    logic [COUNTER_W-1:0]        shadow_d [NUM_EVENTS];
    logic [COUNTER_W:0]          sum      [NUM_EVENTS];
    logic [NUM_EVENTS-1:0]       overflow_q, overflow_d;
    logic [WINDOW_W-1:0]         remaining_q, remaining_d;
    logic                        rdValid_q, rdErr_q;
    logic [COUNTER_W-1:0]        rdData_q;
    logic [COUNTER_W-1:0]        ovfWord;
    logic                        winStart, countActive, windowEnd;

    always_comb begin
        winStart    = win_start_i && (win_len_i != '0);
        countActive = (state_q == COUNTING) || ((state_q == IDLE) && count_en_i);
        windowEnd   = (state_q == COUNTING) && (remaining_q == WINDOW_W'(1));
    end

    always_comb begin
        for (int i = 0; i < NUM_EVENTS; i++) begin
            sum[i] = {1'b0, cnt_q[i]} + (COUNTER_W+1)'(events_q[i*INC_W +: INC_W]);
        end
    end

    // win_start outranks clear, which outranks the increment; the carry bit marks overflow
    always_comb begin
        cnt_d      = cnt_q;
        overflow_d = overflow_q;
        for (int i = 0; i < NUM_EVENTS; i++) begin
            if (winStart || clear_i) begin
                cnt_d[i]      = '0;
                overflow_d[i] = 1'b0;
            end else if (countActive) begin
                if (sum[i][COUNTER_W]) begin
                    overflow_d[i] = 1'b1;
                    cnt_d[i]      = (SATURATE != 0) ? {COUNTER_W{1'b1}} : sum[i][COUNTER_W-1:0];
                end else begin
                    cnt_d[i] = sum[i][COUNTER_W-1:0];
                end
            end
        end
    end

    // End of window captures post-increment values; a plain snapshot captures pre-update values
    always_comb begin
        shadow_d = shadow_q;
        if (windowEnd && !winStart) begin
            shadow_d = cnt_d;
        end else if (snapshot_i) begin
            shadow_d = cnt_q;
        end
    end

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        case (state_q)
            IDLE: ;
            COUNTING: begin
                remaining_d = remaining_q - WINDOW_W'(1);
                if (windowEnd) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (winStart) begin
            state_d     = COUNTING;
            remaining_d = win_len_i;
        end
    end

    always_comb begin
        ovfWord                = '0;
        ovfWord[OVF_BITS-1:0]  = overflow_q[OVF_BITS-1:0];
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q     <= IDLE;
            events_q    <= '0;
            remaining_q <= '0;
            overflow_q  <= '0;
            rdValid_q   <= 1'b0;
            rdErr_q     <= 1'b0;
            rdData_q    <= '0;
            for (int i = 0; i < NUM_EVENTS; i++) begin
                cnt_q[i]    <= '0;
                shadow_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            events_q    <= events_i;
            remaining_q <= remaining_d;
            overflow_q  <= overflow_d;
            for (int i = 0; i < NUM_EVENTS; i++) begin
                cnt_q[i]    <= cnt_d[i];
                shadow_q[i] <= shadow_d[i];
            end
            rdValid_q <= rd_req_i;
            rdErr_q   <= 1'b0;
            if (rd_req_i) begin
                if (rd_sel_i[SEL_W-1]) begin
                    rdData_q <= ovfWord;
                end else if (32'(rd_sel_i[SEL_W-2:0]) < NUM_EVENTS) begin
                    rdData_q <= shadow_q[rd_sel_i[SEL_W-2:0]];
                end else begin
                    rdData_q <= '0;
                    rdErr_q  <= 1'b1;
                end
            end
        end
    end

`ifdef TAIGA_EVENT_COUNTER_IRQ_EN
    logic doneLatch_q, ctrIrq_q;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            doneLatch_q <= 1'b0;
            ctrIrq_q    <= 1'b0;
        end else begin
            if (clear_i || win_start_i) begin
                doneLatch_q <= 1'b0;
            end else if (state_q == DONE) begin
                doneLatch_q <= 1'b1;
            end
            ctrIrq_q <= (|(overflow_q & ~irq_mask_i)) | doneLatch_q;
        end
    end

    assign ctr_irq_o = ctrIrq_q;
`endif

    assign win_busy_o = (state_q == COUNTING);
    assign win_done_o = (state_q == DONE);
    assign rd_valid_o = rdValid_q;
    assign rd_data_o  = rdData_q;
    assign rd_err_o   = rdErr_q;
    assign overflow_o = overflow_q;

endmodule

// File: tb/tb_taiga_event_counters.sv
// Bench for taiga_event_counters: two 8-bit instances (wrapping and saturating) share stimulus;
// directed scenarios use constant expectations, the random phase uses an arithmetic model.
module tb_taiga_event_counters;

    localparam int NE   = 27;
    localparam int IW   = 3;
    localparam int CW   = 8;
    localparam int WW   = 24;
    localparam int SW   = 6;
    localparam int CMAX = 255;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst, countEn, clear, snapshot, winStart, rdReq;
    logic [NE*IW-1:0]    events;
    logic [WW-1:0]       winLen;
    logic [SW-1:0]       rdSel;
    logic                busyW, doneW, rvW, errW, busyS, doneS, rvS, errS;
    logic [CW-1:0]       rdW, rdS;
    logic [NE-1:0]       ovfW, ovfS;
`ifdef TAIGA_EVENT_COUNTER_IRQ_EN
    logic [NE-1:0]       irqMask;
    logic                irqW, irqS;
`endif

    int testsRun  = 0;
    int failCount = 0;

    taiga_event_counters #(.NUM_EVENTS(NE), .INC_W(IW), .COUNTER_W(CW), .SATURATE(0), .WINDOW_W(WW)) dutWrap (
        .clk_i(clk), .rst_i(rst), .events_i(events), .count_en_i(countEn), .clear_i(clear),
        .snapshot_i(snapshot), .win_start_i(winStart), .win_len_i(winLen), .win_busy_o(busyW),
        .win_done_o(doneW), .rd_req_i(rdReq), .rd_sel_i(rdSel), .rd_valid_o(rvW), .rd_data_o(rdW),
        .rd_err_o(errW), .overflow_o(ovfW)
`ifdef TAIGA_EVENT_COUNTER_IRQ_EN
        , .ctr_irq_o(irqW), .irq_mask_i(irqMask)
`endif
    );

    taiga_event_counters #(.NUM_EVENTS(NE), .INC_W(IW), .COUNTER_W(CW), .SATURATE(1), .WINDOW_W(WW)) dutSat (
        .clk_i(clk), .rst_i(rst), .events_i(events), .count_en_i(countEn), .clear_i(clear),
        .snapshot_i(snapshot), .win_start_i(winStart), .win_len_i(winLen), .win_busy_o(busyS),
        .win_done_o(doneS), .rd_req_i(rdReq), .rd_sel_i(rdSel), .rd_valid_o(rvS), .rd_data_o(rdS),
        .rd_err_o(errS), .overflow_o(ovfS)
`ifdef TAIGA_EVENT_COUNTER_IRQ_EN
        , .ctr_irq_o(irqS), .irq_mask_i(irqMask)
`endif
    );

    // Reference model: index 0 wraps, index 1 saturates
    int mCnt    [2][NE];
    int mShadow [2][NE];
    bit mOvf    [2][NE];
    int regEv   [NE];
    bit mBusy, mDone, eRv, eErr;
    int mRem;
    int eRd [2];

    task automatic modelStep();
        bit startW, endW, active;
        int oldC, newC, t, word;
        if (!rst) begin
            for (int s = 0; s < 2; s++) begin
                for (int i = 0; i < NE; i++) begin
                    mCnt[s][i] = 0; mShadow[s][i] = 0; mOvf[s][i] = 0;
                end
                eRd[s] = 0;
            end
            for (int i = 0; i < NE; i++) regEv[i] = 0;
            mBusy = 0; mDone = 0; mRem = 0; eRv = 0; eErr = 0;
            return;
        end
        startW = winStart && (winLen != 0);
        endW   = mBusy && (mRem == 1);
        active = mBusy || (!mDone && countEn);
        eRv    = rdReq;
        eErr   = 0;
        for (int s = 0; s < 2; s++) begin
            if (rdReq) begin
                if (rdSel[SW-1]) begin
                    word = 0;
                    for (int i = 0; i < CW; i++) if (mOvf[s][i]) word += (1 << i);
                    eRd[s] = word;
                end else if (rdSel < NE) begin
                    eRd[s] = mShadow[s][rdSel];
                end else begin
                    eRd[s] = 0;
                    eErr   = 1;
                end
            end
            for (int i = 0; i < NE; i++) begin
                oldC = mCnt[s][i];
                newC = oldC;
                if (startW || clear) begin
                    newC = 0;
                    mOvf[s][i] = 0;
                end else if (active) begin
                    t = oldC + regEv[i];
                    if (t > CMAX) begin
                        mOvf[s][i] = 1;
                        newC = (s == 1) ? CMAX : t - (CMAX + 1);
                    end else begin
                        newC = t;
                    end
                end
                if (endW && !startW) mShadow[s][i] = newC;
                else if (snapshot)   mShadow[s][i] = oldC;
                mCnt[s][i] = newC;
            end
        end
        mDone = endW && !startW;
        if (startW) begin
            mBusy = 1;
            mRem  = int'(winLen);
        end else if (mBusy) begin
            mRem--;
            if (endW) mBusy = 0;
        end
        for (int i = 0; i < NE; i++) regEv[i] = int'(events[i*IW +: IW]);
    endtask

    function automatic logic [NE-1:0] ovfVec(int s);
        logic [NE-1:0] v;
        for (int i = 0; i < NE; i++) v[i] = mOvf[s][i];
        return v;
    endfunction

    task automatic applyStimulus();
        modelStep();
        @(posedge clk);
        #1;
        clear    = 1'b0;
        snapshot = 1'b0;
        winStart = 1'b0;
        rdReq    = 1'b0;
    endtask

    task automatic checkOutput(string tag, logic [63:0] observed, logic [63:0] expected);
        testsRun++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic setEv(int ch, int val);
        events[ch*IW +: IW] = IW'(val);
    endtask

    task automatic readBoth(int sel);
        rdReq = 1'b1;
        rdSel = SW'(sel);
        applyStimulus();
    endtask

    int busyCnt, doneCnt;

    initial begin
        rst = 1'b0; countEn = 1'b0; clear = 1'b0; snapshot = 1'b0; winStart = 1'b0;
        rdReq = 1'b0; events = '0; winLen = '0; rdSel = '0;
`ifdef TAIGA_EVENT_COUNTER_IRQ_EN
        irqMask = '1;
`endif
        applyStimulus();
        applyStimulus();
        checkOutput("reset_busy",  64'(busyW), 64'(0));
        checkOutput("reset_done",  64'(doneW), 64'(0));
        checkOutput("reset_valid", 64'(rvW),   64'(0));
        checkOutput("reset_data",  64'(rdW),   64'(0));
        checkOutput("reset_err",   64'(errW),  64'(0));
        checkOutput("reset_ovfW",  64'(ovfW),  64'(0));
        checkOutput("reset_ovfS",  64'(ovfS),  64'(0));
        rst = 1'b1;
        applyStimulus();

        // Free-running count on channel 3
        countEn = 1'b1;
        setEv(3, 1);
        repeat (10) applyStimulus();
        events = '0;
        applyStimulus();
        countEn = 1'b0;
        applyStimulus();
        snapshot = 1'b1;
        applyStimulus();
        readBoth(3);
        checkOutput("free_valid", 64'(rvW),  64'(1));
        checkOutput("free_dataW", 64'(rdW),  64'(10));
        checkOutput("free_dataS", 64'(rdS),  64'(10));
        checkOutput("free_err",   64'(errW), 64'(0));
        applyStimulus();
        checkOutput("free_valid_drop", 64'(rvW), 64'(0));

        // Channel 0 at 5 per cycle for 52 cycles: 260 wraps to 4 or saturates at 255
        clear = 1'b1;
        applyStimulus();
        countEn = 1'b1;
        setEv(0, 5);
        repeat (52) applyStimulus();
        events = '0;
        applyStimulus();
        countEn = 1'b0;
        applyStimulus();
        snapshot = 1'b1;
        applyStimulus();
        readBoth(0);
        checkOutput("wrap_data", 64'(rdW),  64'(4));
        checkOutput("sat_data",  64'(rdS),  64'(255));
        checkOutput("wrap_ovf",  64'(ovfW), 64'(1));
        checkOutput("sat_ovf",   64'(ovfS), 64'(1));
        readBoth(32);
        checkOutput("ovfword_data", 64'(rdW),  64'(1));
        checkOutput("ovfword_err",  64'(errW), 64'(0));

        // 16-cycle window with channel 1 at 2 per cycle
        clear = 1'b1;
        applyStimulus();
        setEv(1, 2);
        winLen   = WW'(16);
        winStart = 1'b1;
        applyStimulus();
        busyCnt = 0;
        doneCnt = 0;
        for (int k = 0; k < 40; k++) begin
            if (busyW) busyCnt++;
            if (doneW) doneCnt++;
            applyStimulus();
        end
        checkOutput("win_busy_cycles", 64'(busyCnt), 64'(16));
        checkOutput("win_done_pulses", 64'(doneCnt), 64'(1));
        readBoth(1);
        checkOutput("win_shadowW", 64'(rdW), 64'(32));
        checkOutput("win_shadowS", 64'(rdS), 64'(32));
        snapshot = 1'b1;
        applyStimulus();
        readBoth(1);
        checkOutput("win_after_idle", 64'(rdW), 64'(32));
        events = '0;

        // clear and snapshot together keep the pre-clear value in the shadow
        clear = 1'b1;
        applyStimulus();
        countEn = 1'b1;
        setEv(4, 7);
        applyStimulus();
        events = '0;
        applyStimulus();
        countEn = 1'b0;
        clear    = 1'b1;
        snapshot = 1'b1;
        applyStimulus();
        readBoth(4);
        checkOutput("clrsnap_shadow", 64'(rdW), 64'(7));
        snapshot = 1'b1;
        applyStimulus();
        readBoth(4);
        checkOutput("clrsnap_live", 64'(rdW), 64'(0));
        readBoth(NE);
        checkOutput("range_valid", 64'(rvW),  64'(1));
        checkOutput("range_data",  64'(rdW),  64'(0));
        checkOutput("range_err",   64'(errW), 64'(1));

        // Reset in the middle of a 100-cycle window
        setEv(2, 3);
        winLen   = WW'(100);
        winStart = 1'b1;
        applyStimulus();
        for (int k = 0; k < 49; k++) begin
            if (k == 30) snapshot = 1'b1;
            applyStimulus();
        end
        events = '0;
        checkOutput("midwin_busy", 64'(busyW), 64'(1));
        rst = 1'b0;
        applyStimulus();
        checkOutput("rst_busy", 64'(busyW), 64'(0));
        checkOutput("rst_ovf",  64'(ovfW),  64'(0));
        rst = 1'b1;
        for (int s = 0; s < 4; s++) begin
            readBoth(s);
            checkOutput("rst_read_valid", 64'(rvW), 64'(1));
            checkOutput("rst_read_data",  64'(rdW), 64'(0));
        end

`ifdef TAIGA_EVENT_COUNTER_IRQ_EN
        clear = 1'b1;
        applyStimulus();
        irqMask = '1;
        countEn = 1'b1;
        setEv(2, 7);
        repeat (40) applyStimulus();
        events = '0;
        applyStimulus();
        countEn = 1'b0;
        applyStimulus();
        checkOutput("irq_ovf2",   64'(ovfW[2]), 64'(1));
        checkOutput("irq_masked", 64'(irqW),    64'(0));
        irqMask = '0;
        applyStimulus();
        checkOutput("irq_unmasked", 64'(irqW), 64'(1));
        clear = 1'b1;
        applyStimulus();
        applyStimulus();
        checkOutput("irq_cleared", 64'(irqW), 64'(0));
        irqMask = '1;
`endif

        // Randomized traffic checked against the model every cycle
        rst = 1'b0;
        applyStimulus();
        rst = 1'b1;
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int i = 0; i < NE; i++) setEv(i, int'($urandom_range(0, 7)));
            countEn  = 1'($urandom_range(0, 1));
            clear    = ($urandom_range(0, 19) == 0);
            snapshot = ($urandom_range(0, 5) == 0);
            winStart = ($urandom_range(0, 24) == 0);
            winLen   = WW'($urandom_range(0, 12));
            rdReq    = 1'($urandom_range(0, 1));
            rdSel    = ($urandom_range(0, 1) == 0) ? SW'($urandom_range(0, NE - 1)) : SW'($urandom_range(0, 63));
            applyStimulus();
            checkOutput("rnd_busy",  64'(busyW), 64'(mBusy));
            checkOutput("rnd_done",  64'(doneW), 64'(mDone));
            checkOutput("rnd_valid", 64'(rvW),   64'(eRv));
            checkOutput("rnd_err",   64'(errW),  64'(eErr));
            checkOutput("rnd_dataW", 64'(rdW),   64'(eRd[0]));
            checkOutput("rnd_dataS", 64'(rdS),   64'(eRd[1]));
            checkOutput("rnd_ovfW",  64'(ovfW),  64'(ovfVec(0)));
            checkOutput("rnd_ovfS",  64'(ovfS),  64'(ovfVec(1)));
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
